// File: rtl/lgn_category_argmax_seq.sv
// lgn_category_argmax_seq
//   Time-multiplexed category popcount and arg-max stage that follows the
//   logic-gate network. Each transaction captures one flattened vector of
//   category vote bits. The block popcounts CHUNK_BITS bits per cycle into a
//   per-category accumulator and keeps a running best score. It then returns
//   the winning category index and its score.
//
//   Optional build macro: ARGMAX_MARGIN_EN
//     When defined, the block also tracks the runner-up score and reports
//     out_margin = best - runner-up.
//     When undefined, out_margin is tied to 0.
//
//   Ports
//     clk        clock, all state on rising edge
//     rst        asynchronous, active-high reset
//     in_valid   in_data valid
//     in_ready   block can accept in_data (IDLE only)
//     in_data    category c occupies [c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]
//     out_valid  result valid (DONE)
//     out_ready  consumer accepts result
//     out_index  winning category (ties keep the lower index)
//     out_value  winning popcount
//     out_margin best minus runner-up score (0 when margin tracking is off)
//     busy       high while counting
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready=1
//   COUNT | one chunk popcounted per cycle, category by category
//   DONE  | result held on out_*; waits for out_ready
module lgn_category_argmax_seq #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 255,
  parameter int CHUNK_BITS        = 64,
  localparam int CHUNKS = (BITS_PER_CATEGORY + CHUNK_BITS - 1) / CHUNK_BITS,
  localparam int SUM_W  = $clog2(BITS_PER_CATEGORY + 1),
  localparam int IDX_W  = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [IDX_W-1:0]                        out_index,
  output logic [SUM_W-1:0]                        out_value,
  output logic [SUM_W-1:0]                        out_margin,
  output logic                                    busy
);

  localparam int CH_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int POP_W = $clog2(CHUNK_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] cap_data;
  logic [IDX_W-1:0] cat_cnt;
  logic [CH_W-1:0]  chunk_cnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] best_value;
  logic [IDX_W-1:0] best_index;

  // Chunk view of the captured vector. The final chunk of each category is
  // zero-padded so the popcount never picks up the next category's bits.
  logic [CHUNK_BITS-1:0] chunk_arr [CATEGORIES][CHUNKS];

  for (genvar c = 0; c < CATEGORIES; c++) begin : g_cat
    for (genvar k = 0; k < CHUNKS; k++) begin : g_chunk
      localparam int LO = c*BITS_PER_CATEGORY + k*CHUNK_BITS;
      if ((k + 1)*CHUNK_BITS <= BITS_PER_CATEGORY) begin : g_full
        assign chunk_arr[c][k] = cap_data[LO +: CHUNK_BITS];
      end else begin : g_pad
        localparam int VALID = BITS_PER_CATEGORY - k*CHUNK_BITS;
        assign chunk_arr[c][k] = {{(CHUNK_BITS - VALID){1'b0}}, cap_data[LO +: VALID]};
      end
    end
  end

  logic [CHUNK_BITS-1:0] chunk;
  logic [POP_W-1:0]      pop;
  logic [SUM_W-1:0]      acc_next;
  logic                  last_chunk;
  logic                  last_cat;
  logic                  take;
  logic [SUM_W-1:0]      nxt_best;
  logic [IDX_W-1:0]      nxt_index;

  assign chunk = chunk_arr[cat_cnt][chunk_cnt];

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHUNK_BITS; i++) begin
      pop = pop + POP_W'(chunk[i]);
    end
  end

  assign acc_next   = acc + SUM_W'(pop);
  assign last_chunk = (chunk_cnt == CH_W'(CHUNKS - 1));
  assign last_cat   = (cat_cnt == IDX_W'(CATEGORIES - 1));
  // Category 0 always seeds the best; later categories must be strictly
  // greater, so ties resolve to the lower index.
  assign take       = (cat_cnt == '0) || (acc_next > best_value);
  assign nxt_best   = take ? acc_next : best_value;
  assign nxt_index  = take ? cat_cnt : best_index;

`ifdef ARGMAX_MARGIN_EN
  logic [SUM_W-1:0] second_value;
  logic [SUM_W-1:0] nxt_second;

  // A displaced best becomes the runner-up; otherwise the score only
  // competes with the current runner-up.
  assign nxt_second = take ? best_value :
                      ((acc_next > second_value) ? acc_next : second_value);
`else
  assign out_margin = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_index  <= '0;
      out_value  <= '0;
      cap_data   <= '0;
      cat_cnt    <= '0;
      chunk_cnt  <= '0;
      acc        <= '0;
      best_value <= '0;
      best_index <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_value <= '0;
      out_margin   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_data   <= in_data;
            cat_cnt    <= '0;
            chunk_cnt  <= '0;
            acc        <= '0;
            best_value <= '0;
            best_index <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_value <= '0;
`endif
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= COUNT;
          end
        end
        COUNT: begin
          if (!last_chunk) begin
            acc       <= acc_next;
            chunk_cnt <= chunk_cnt + 1'b1;
          end else begin
            acc        <= '0;
            chunk_cnt  <= '0;
            best_value <= nxt_best;
            best_index <= nxt_index;
`ifdef ARGMAX_MARGIN_EN
            second_value <= nxt_second;
`endif
            if (last_cat) begin
              out_index <= nxt_index;
              out_value <= nxt_best;
`ifdef ARGMAX_MARGIN_EN
              out_margin <= nxt_best - nxt_second;
`endif
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else begin
              cat_cnt <= cat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lgn_category_argmax_seq.sv
// Testbench for lgn_category_argmax_seq: a default-size instance (10x255,
// 64-bit chunks) and a small instance (3x5, 2-bit chunks) that exercises
// the padding of the last chunk. Expected results come from a reference
// model of popcount/arg-max/runner-up and are queued when a transaction is
// accepted, then popped when the result handshake occurs.
module tb_lgn_category_argmax_seq;

  localparam int A_CAT = 10, A_BPC = 255, A_CB = 64;
  localparam int A_W = A_CAT*A_BPC;
  localparam int A_LAT = 41;
  localparam int B_CAT = 3, B_BPC = 5, B_CB = 2;
  localparam int B_W = B_CAT*B_BPC;
  localparam int B_LAT = 10;
`ifdef ARGMAX_MARGIN_EN
  localparam bit MARGIN_ON = 1'b1;
`else
  localparam bit MARGIN_ON = 1'b0;
`endif

  typedef struct { int idx; int val; int mrg; } exp_t;

  logic clk, rst;

  logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [A_W-1:0] a_in_data;
  logic [3:0]     a_out_index;
  logic [7:0]     a_out_value, a_out_margin;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [B_W-1:0] b_in_data;
  logic [1:0]     b_out_index;
  logic [2:0]     b_out_value, b_out_margin;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int n_vec = 0;
  int n_err = 0;

  lgn_category_argmax_seq #(.CATEGORIES(A_CAT), .BITS_PER_CATEGORY(A_BPC), .CHUNK_BITS(A_CB)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_index(a_out_index),
    .out_value(a_out_value), .out_margin(a_out_margin), .busy(a_busy));

  lgn_category_argmax_seq #(.CATEGORIES(B_CAT), .BITS_PER_CATEGORY(B_BPC), .CHUNK_BITS(B_CB)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
    .out_value(b_out_value), .out_margin(b_out_margin), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: argmax with lowest index on ties, runner-up is the best score
  // among all categories other than the winner.
  function automatic exp_t model(input int s[16], input int n);
    exp_t e;
    int second;
    e.idx = 0;
    e.val = s[0];
    for (int c = 1; c < n; c++) if (s[c] > e.val) begin e.idx = c; e.val = s[c]; end
    second = 0;
    for (int c = 0; c < n; c++) if (c != e.idx && s[c] > second) second = s[c];
    e.mrg = MARGIN_ON ? (e.val - second) : 0;
    return e;
  endfunction

  function automatic exp_t model_a(input logic [A_W-1:0] d);
    int s[16];
    logic [A_W-1:0] t;
    for (int c = 0; c < 16; c++) s[c] = 0;
    for (int c = 0; c < A_CAT; c++) begin
      t = d >> (c*A_BPC);
      s[c] = $countones(t[A_BPC-1:0]);
    end
    return model(s, A_CAT);
  endfunction

  function automatic exp_t model_b(input logic [B_W-1:0] d);
    int s[16];
    logic [B_W-1:0] t;
    for (int c = 0; c < 16; c++) s[c] = 0;
    for (int c = 0; c < B_CAT; c++) begin
      t = d >> (c*B_BPC);
      s[c] = $countones(t[B_BPC-1:0]);
    end
    return model(s, B_CAT);
  endfunction

  function automatic logic [A_W-1:0] mk_a(input int cnt[A_CAT]);
    logic [A_W-1:0] d;
    d = '0;
    for (int c = 0; c < A_CAT; c++)
      for (int b = 0; b < cnt[c]; b++) d[c*A_BPC + b] = 1'b1;
    return d;
  endfunction

  // Drives one input at a negedge, returns at the negedge after the accept edge.
  task automatic accept_a(input logic [A_W-1:0] d, output bit ok);
    ok = 1'b0;
    a_in_data  = d;
    a_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (a_in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      sb_a.push_back(model_a(d));
      @(posedge clk);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic accept_b(input logic [B_W-1:0] d, output bit ok);
    ok = 1'b0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (b_in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      sb_b.push_back(model_b(d));
      @(posedge clk);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; cyc is the cycle index counting
  // the accept cycle as 0.
  task automatic wait_out_a(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 1;
    for (int i = 0; i < 200; i++) begin
      if (a_out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_out_b(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 1;
    for (int i = 0; i < 200; i++) begin
      if (b_out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    n_vec++; if (a_out_index !== 4'd0) begin n_err++; $display("FAIL reset_out_index: got %0d expected 0", a_out_index); end
    n_vec++; if (a_out_value !== 8'd0) begin n_err++; $display("FAIL reset_out_value: got %0d expected 0", a_out_value); end
    n_vec++; if (a_out_margin !== 8'd0) begin n_err++; $display("FAIL reset_out_margin: got %0d expected 0", a_out_margin); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_winner();
    int cnt[A_CAT];
    int cyc;
    bit ok;
    exp_t e;
    for (int c = 0; c < A_CAT; c++) cnt[c] = 10;
    cnt[3] = 200;
    a_out_ready = 1'b1;
    accept_a(mk_a(cnt), ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_accept: got timeout expected accept"); return; end
    wait_out_a(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_out_valid: got timeout expected out_valid"); return; end
    n_vec++; if (cyc != A_LAT) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", cyc, A_LAT); end
    e = sb_a.pop_front();
    n_vec++; if (a_out_index !== 4'(e.idx)) begin n_err++; $display("FAIL single_index: got %0d expected %0d", a_out_index, e.idx); end
    n_vec++; if (a_out_value !== 8'(e.val)) begin n_err++; $display("FAIL single_value: got %0d expected %0d", a_out_value, e.val); end
    n_vec++; if (a_out_margin !== 8'(e.mrg)) begin n_err++; $display("FAIL single_margin: got %0d expected %0d", a_out_margin, e.mrg); end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int cnt[A_CAT];
    int cyc;
    bit ok;
    exp_t e;
    for (int c = 0; c < A_CAT; c++) cnt[c] = 0;
    cnt[2] = 255;
    cnt[7] = 255;
    a_out_ready = 1'b1;
    accept_a(mk_a(cnt), ok);
    wait_out_a(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL tie_out_valid: got timeout expected out_valid"); return; end
    e = sb_a.pop_front();
    n_vec++; if (a_out_index !== 4'(e.idx)) begin n_err++; $display("FAIL tie_index: got %0d expected %0d", a_out_index, e.idx); end
    n_vec++; if (a_out_value !== 8'(e.val)) begin n_err++; $display("FAIL tie_value: got %0d expected %0d", a_out_value, e.val); end
    n_vec++; if (a_out_margin !== 8'(e.mrg)) begin n_err++; $display("FAIL tie_margin: got %0d expected %0d", a_out_margin, e.mrg); end
    @(negedge clk);
  endtask

  task automatic test_zero_hold();
    int cyc;
    bit ok;
    exp_t e;
    a_out_ready = 1'b0;
    accept_a('0, ok);
    wait_out_a(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL zero_out_valid: got timeout expected out_valid"); return; end
    e = sb_a.pop_front();
    n_vec++; if (a_out_index !== 4'(e.idx)) begin n_err++; $display("FAIL zero_index: got %0d expected %0d", a_out_index, e.idx); end
    n_vec++; if (a_out_value !== 8'(e.val)) begin n_err++; $display("FAIL zero_value: got %0d expected %0d", a_out_value, e.val); end
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_index !== 4'(e.idx) ||
          a_out_value !== 8'(e.val) || a_out_margin !== 8'(e.mrg)) begin
        n_err++;
        $display("FAIL zero_hold_%0d: got valid=%b ready=%b idx=%0d val=%0d expected valid=1 ready=0 idx=%0d val=%0d",
                 i, a_out_valid, a_in_ready, a_out_index, a_out_value, e.idx, e.val);
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_release: got valid=%b ready=%b expected valid=0 ready=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_mid_reset();
    int cnt[A_CAT];
    int cyc;
    int seen;
    bit ok;
    exp_t e;
    for (int c = 0; c < A_CAT; c++) cnt[c] = 0;
    cnt[9] = 128;
    a_out_ready = 1'b1;
    accept_a(mk_a(cnt), ok);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_a.delete();
    n_vec++;
    if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state: got ready=%b busy=%b expected ready=1 busy=0", a_in_ready, a_busy);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL midrst_no_out: got %0d valid cycles expected 0", seen); end
    accept_a(mk_a(cnt), ok);
    wait_out_a(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_resubmit: got timeout expected out_valid"); return; end
    e = sb_a.pop_front();
    n_vec++; if (a_out_index !== 4'(e.idx)) begin n_err++; $display("FAIL midrst_index: got %0d expected %0d", a_out_index, e.idx); end
    n_vec++; if (a_out_value !== 8'(e.val)) begin n_err++; $display("FAIL midrst_value: got %0d expected %0d", a_out_value, e.val); end
    n_vec++; if (a_out_margin !== 8'(e.mrg)) begin n_err++; $display("FAIL midrst_margin: got %0d expected %0d", a_out_margin, e.mrg); end
    @(negedge clk);
  endtask

  task automatic test_small_padding();
    logic [B_W-1:0] d;
    int cyc;
    bit ok;
    exp_t e;
    d = {5'b00001, 5'b10101, 5'b11111};
    b_out_ready = 1'b1;
    accept_b(d, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL small_accept: got timeout expected accept"); return; end
    wait_out_b(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL small_out_valid: got timeout expected out_valid"); return; end
    n_vec++; if (cyc != B_LAT) begin n_err++; $display("FAIL small_latency: got %0d expected %0d", cyc, B_LAT); end
    e = sb_b.pop_front();
    n_vec++; if (b_out_index !== 2'(e.idx)) begin n_err++; $display("FAIL small_index: got %0d expected %0d", b_out_index, e.idx); end
    n_vec++; if (b_out_value !== 3'(e.val)) begin n_err++; $display("FAIL small_value: got %0d expected %0d", b_out_value, e.val); end
    n_vec++; if (b_out_margin !== 3'(e.mrg)) begin n_err++; $display("FAIL small_margin: got %0d expected %0d", b_out_margin, e.mrg); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cnt[A_CAT];
    logic [A_W-1:0] d1, d2;
    int acc_cyc[2];
    int n_acc, n_res, cyc;
    exp_t e;
    for (int c = 0; c < A_CAT; c++) cnt[c] = 3;
    cnt[5] = 77;
    d1 = mk_a(cnt);
    for (int c = 0; c < A_CAT; c++) cnt[c] = c;
    cnt[8] = 250;
    cnt[1] = 249;
    d2 = mk_a(cnt);
    a_out_ready = 1'b1;
    a_in_data = d1;
    a_in_valid = 1'b1;
    n_acc = 0; n_res = 0; cyc = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    while (n_res < 2 && cyc < 300) begin
      if (a_in_valid === 1'b1 && a_in_ready === 1'b1 && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        sb_a.push_back(model_a(a_in_data));
        n_acc++;
      end
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
        n_vec++;
        if (sb_a.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: got out_valid expected none");
        end else begin
          e = sb_a.pop_front();
          if (a_out_index !== 4'(e.idx) || a_out_value !== 8'(e.val) || a_out_margin !== 8'(e.mrg)) begin
            n_err++;
            $display("FAIL b2b_result_%0d: got idx=%0d val=%0d mrg=%0d expected idx=%0d val=%0d mrg=%0d",
                     n_res, a_out_index, a_out_value, a_out_margin, e.idx, e.val, e.mrg);
          end
        end
        n_res++;
      end
      @(negedge clk);
      cyc++;
      if (n_acc == 1) a_in_data = d2;
      if (n_acc == 2) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    n_vec++; if (n_res != 2) begin n_err++; $display("FAIL b2b_results: got %0d expected 2", n_res); end
    n_vec++;
    if (acc_cyc[1] - acc_cyc[0] != A_LAT + 1) begin
      n_err++;
      $display("FAIL b2b_accept_gap: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], A_LAT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_tie();
    test_zero_hold();
    test_mid_reset();
    test_small_padding();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
